fifo_serializer: RTL and testbench

FIFO_SERIALIZER -- requirements
Module: fifo_serializer

---
 rtl/fifo_serializer.sv | 130 +++++++++++++
 tb/tb_fifo_serializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serializer.sv
// Pops words from a FIFO read port and sends each one as a UART-style frame:
// a start bit, the data bits LSB first, an optional parity bit, then a stop bit.
module fifo_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PAR_EN       = 1,
    parameter int PAR_TYP      = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  R_INC,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int              BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [7:0]      CNT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    last_cyc;
    logic                    pop;

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d);
        return (^d) ^ (PAR_TYP != 0);
    endfunction

    // Pop is combinational so the word is taken in the same cycle EMPTY drops;
    // gating with RST keeps the strobe low while reset is held.
    assign last_cyc = (cnt_q == CNT_LAST);
    assign pop      = RST & ~EMPTY & ((state_q == IDLE) | ((state_q == STOP) & last_cyc));

    assign R_INC  = pop;
    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

    // State, counters, latched word and the registered line outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= {BW{1'b0}};
            data_q  <= {DATA_WIDTH{1'b0}};
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and counter sequencing; a pop always restarts at START
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        if (pop) begin
            state_d = START;
            cnt_d   = 8'd0;
            bit_d   = {BW{1'b0}};
            data_d  = RD_DATA;
        end else if (state_q != IDLE) begin
            if (!last_cyc) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = 8'd0;
                case (state_q)
                    START: begin
                        state_d = DATA;
                        bit_d   = {BW{1'b0}};
                    end
                    DATA: begin
                        if (bit_q == BIT_LAST) begin
                            if (PAR_EN != 0) begin
                                state_d = PARITY;
                            end else begin
                                state_d = STOP;
                            end
                        end else begin
                            bit_d = bit_q + BW'(1'b1);
                        end
                    end
                    PARITY:  state_d = STOP;
                    STOP:    state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end else begin
            cnt_d = 8'd0;
        end
    end

    // Line level and BUSY for the coming cycle, decoded from the next state
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            IDLE:    busy_d = 1'b0;
            START:   tx_d   = 1'b0;
            DATA:    tx_d   = data_d[bit_d];
            PARITY:  tx_d   = parity_bit(data_d);
            STOP:    tx_d   = 1'b1;
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// Self-checking bench: four serializer variants against a frame model built
// from bit position arithmetic, with random FIFO activity during frames.
module tb_fifo_serializer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       empty [4];
    logic [7:0] rd    [4];
    logic       r_inc [4];
    logic       tx    [4];
    logic       busy  [4];

    int checks   = 0;
    int failures = 0;

    int cpb_a [4] = '{1, 1, 1, 4};
    int pe_a  [4] = '{1, 1, 0, 1};
    int pt_a  [4] = '{0, 1, 0, 0};

    int pulses [4] = '{0, 0, 0, 0};
    int pcyc   [4] = '{0, 0, 0, 0};
    int pprev  [4] = '{0, 0, 0, 0};
    int viol = 0;
    int cyc  = 0;

    logic [7:0] wq[$];

    always #5 clk = ~clk;

    fifo_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PAR_EN(1), .PAR_TYP(0)) u_even (
        .CLK(clk), .RST(rst_n), .EMPTY(empty[0]), .RD_DATA(rd[0]),
        .R_INC(r_inc[0]), .TX_OUT(tx[0]), .BUSY(busy[0]));
    fifo_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PAR_EN(1), .PAR_TYP(1)) u_odd (
        .CLK(clk), .RST(rst_n), .EMPTY(empty[1]), .RD_DATA(rd[1]),
        .R_INC(r_inc[1]), .TX_OUT(tx[1]), .BUSY(busy[1]));
    fifo_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PAR_EN(0), .PAR_TYP(0)) u_nopar (
        .CLK(clk), .RST(rst_n), .EMPTY(empty[2]), .RD_DATA(rd[2]),
        .R_INC(r_inc[2]), .TX_OUT(tx[2]), .BUSY(busy[2]));
    fifo_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PAR_EN(1), .PAR_TYP(0)) u_slow (
        .CLK(clk), .RST(rst_n), .EMPTY(empty[3]), .RD_DATA(rd[3]),
        .R_INC(r_inc[3]), .TX_OUT(tx[3]), .BUSY(busy[3]));

    // Pop monitor: counts strobes, remembers when they happened, flags pops on empty
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 4; k++) begin
            if (r_inc[k] === 1'b1) begin
                pulses[k] <= pulses[k] + 1;
                pprev[k]  <= pcyc[k];
                pcyc[k]   <= cyc;
            end
            if (r_inc[k] === 1'b1 && empty[k] === 1'b1) viol <= viol + 1;
        end
    end

    // Expected line level c cycles into a frame of word d on variant k
    function automatic logic exp_tx(input logic [7:0] d, input int c, input int k);
        int b;
        b = c / cpb_a[k];
        if (b == 0) return 1'b0;
        else if (b <= 8) return d[b-1];
        else if (pe_a[k] != 0 && b == 9) return 1'(($countones(d) % 2) ^ pt_a[k]);
        else return 1'b1;
    endfunction

    // Sends every word in wq on variant k, back-to-back or with an idle gap
    task automatic run_words(input int k, input bit b2b, input string tag);
        int   n;
        int   len;
        int   p0;
        bit   nxt;
        logic exp_b;
        n   = wq.size();
        len = (10 + pe_a[k]) * cpb_a[k];
        p0  = pulses[k];
        @(posedge clk); #1;
        empty[k] = 1'b0;
        rd[k]    = wq[0];
        @(negedge clk);
        checks++;
        if (r_inc[k] !== 1'b1 || tx[k] !== 1'b1 || busy[k] !== 1'b0) begin
            failures++;
            $display("FAIL %s_pop0 k=%0d got r_inc=%b tx=%b busy=%b exp 1 1 0", tag, k, r_inc[k], tx[k], busy[k]);
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            nxt = b2b && (i < n - 1);
            for (int c = 0; c < len; c++) begin
                if (c == len - 1) begin
                    empty[k] = ~nxt;
                    rd[k]    = nxt ? wq[i+1] : 8'($urandom);
                end else begin
                    empty[k] = 1'($urandom_range(0, 1));
                    rd[k]    = 8'($urandom);
                end
                @(negedge clk);
                exp_b = exp_tx(wq[i], c, k);
                checks++;
                if (tx[k] !== exp_b || busy[k] !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_bit k=%0d word=%h c=%0d got tx=%b busy=%b exp tx=%b busy=1",
                             tag, k, wq[i], c, tx[k], busy[k], exp_b);
                end
                checks++;
                if (r_inc[k] !== ((c == len - 1) ? nxt : 1'b0)) begin
                    failures++;
                    $display("FAIL %s_rinc k=%0d word=%h c=%0d got %b exp %b",
                             tag, k, wq[i], c, r_inc[k], (c == len - 1) ? nxt : 1'b0);
                end
                if (c < len - 1) begin
                    @(posedge clk); #1;
                end
            end
            if (!nxt) begin
                @(posedge clk); #1;
                @(negedge clk);
                checks++;
                if (tx[k] !== 1'b1 || busy[k] !== 1'b0 || r_inc[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_idle k=%0d got tx=%b busy=%b r_inc=%b exp 1 0 0", tag, k, tx[k], busy[k], r_inc[k]);
                end
                if (i < n - 1) begin
                    empty[k] = 1'b0;
                    rd[k]    = wq[i+1];
                    #1;
                    checks++;
                    if (r_inc[k] !== 1'b1) begin
                        failures++;
                        $display("FAIL %s_popn k=%0d got %b exp 1", tag, k, r_inc[k]);
                    end
                end
            end
        end
        checks++;
        if (pulses[k] - p0 !== n) begin
            failures++;
            $display("FAIL %s_count k=%0d got %0d exp %0d", tag, k, pulses[k] - p0, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            empty[k] = 1'b0;
            rd[k]    = 8'hFF;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tx[k] !== 1'b1 || busy[k] !== 1'b0 || r_inc[k] !== 1'b0 || pulses[k] !== 0) begin
                failures++;
                $display("FAIL reset k=%0d got tx=%b busy=%b r_inc=%b pulses=%0d exp 1 0 0 0",
                         k, tx[k], busy[k], r_inc[k], pulses[k]);
            end
            empty[k] = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        wq = '{8'hB9};
        run_words(0, 1'b0, "single_b9");
    endtask

    task automatic test_back_to_back();
        wq = '{8'h64, 8'h3E};
        run_words(0, 1'b1, "b2b");
        checks++;
        if (pcyc[0] - pprev[0] !== 11) begin
            failures++;
            $display("FAIL b2b_spacing got %0d exp 11", pcyc[0] - pprev[0]);
        end
    endtask

    task automatic test_parity_modes();
        wq = '{8'h2A};
        run_words(1, 1'b0, "odd_par");
        wq = '{8'h2A};
        run_words(2, 1'b0, "no_par");
    endtask

    task automatic test_slow_bits();
        wq = '{8'h1D};
        run_words(3, 1'b0, "cpb4");
    endtask

    task automatic test_empty_idle();
        for (int k = 0; k < 4; k++) empty[k] = 1'b1;
        for (int t = 0; t < 100; t++) begin
            for (int k = 0; k < 4; k++) rd[k] = 8'($urandom);
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (r_inc[k] !== 1'b0 || tx[k] !== 1'b1 || busy[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL empty_idle k=%0d t=%0d got r_inc=%b tx=%b busy=%b exp 0 1 0",
                             k, t, r_inc[k], tx[k], busy[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int p0;
        @(posedge clk); #1;
        empty[0] = 1'b0;
        rd[0]    = 8'h48;
        @(posedge clk); #1;
        empty[0] = 1'b1;
        rd[0]    = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_bit3 got tx=%b busy=%b exp 1 1", tx[0], busy[0]);
        end
        p0 = pulses[0];
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || r_inc[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async got tx=%b busy=%b r_inc=%b exp 1 0 0", tx[0], busy[0], r_inc[0]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || pulses[0] !== p0) begin
            failures++;
            $display("FAIL rst_mid_abandon got tx=%b busy=%b pops=%0d exp 1 0 0", tx[0], busy[0], pulses[0] - p0);
        end
        wq = '{8'h48};
        run_words(0, 1'b0, "rst_fresh");
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                n = $urandom_range(2, 4);
                wq.delete();
                for (int j = 0; j < n; j++) wq.push_back(8'($urandom));
                run_words(k, 1'($urandom_range(0, 1)), "random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity_modes();
        test_slow_bits();
        test_empty_idle();
        test_reset_midframe();
        test_random();
        @(posedge clk); #1;
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL pop_while_empty got %0d exp 0", viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
